// File: rtl/rp_pkg.sv
// rtl/rp_pkg.sv - function codes and state encoding for the RP drive sequencer
package rp_pkg;

    localparam logic [4:0] FUN_NOP    = 5'd0;
    localparam logic [4:0] FUN_UNLOAD = 5'd1;
    localparam logic [4:0] FUN_SEEK   = 5'd2;
    localparam logic [4:0] FUN_RECAL  = 5'd3;
    localparam logic [4:0] FUN_DRVCLR = 5'd4;
    localparam logic [4:0] FUN_RELEAS = 5'd5;
    localparam logic [4:0] FUN_OFFSET = 5'd6;
    localparam logic [4:0] FUN_RTC    = 5'd7;
    localparam logic [4:0] FUN_PRESET = 5'd8;
    localparam logic [4:0] FUN_PACK   = 5'd9;
    localparam logic [4:0] FUN_SEARCH = 5'd12;
    localparam logic [4:0] FUN_WRCHK  = 5'd20;
    localparam logic [4:0] FUN_WRCHKH = 5'd21;
    localparam logic [4:0] FUN_WRITE  = 5'd24;
    localparam logic [4:0] FUN_WRHD   = 5'd25;
    localparam logic [4:0] FUN_READ   = 5'd28;
    localparam logic [4:0] FUN_RDHD   = 5'd29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POS  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

endpackage

// File: rtl/rp_drive_func_seq.sv
// rtl/rp_drive_func_seq.sv - RP drive-side GO/function sequencer
// Positioning ops burn a delay count; data ops hand off to the transfer engine.
module rp_drive_func_seq
    import rp_pkg::*;
#(
    parameter int SEEK_CYC  = 1000,
    parameter int RECAL_CYC = 4000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drvCLR,
    input  logic       goSTB,
    input  logic [4:0] goFUN,
    input  logic       ataCLR,
    input  logic       xferDONE,
    input  logic       xferERR,
    output logic       rpDRY,
    output logic       rpATA,
    output logic       rpERR,
    output logic       rpILF,
    output logic       rpRMR,
    output logic       xferREQ,
    output logic [4:0] xferFUN,
    output logic       rpVV
);

    localparam logic [CNT_W-1:0] SEEK_LOAD  = CNT_W'(SEEK_CYC - 1);
    localparam logic [CNT_W-1:0] RECAL_LOAD = CNT_W'(RECAL_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] delayCnt;
    logic             xferErrLat;

    assign rpDRY = (state == ST_IDLE);
    assign rpERR = rpILF | rpRMR | xferErrLat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            delayCnt   <= '0;
            xferErrLat <= 1'b0;
            rpATA      <= 1'b0;
            rpILF      <= 1'b0;
            rpRMR      <= 1'b0;
            xferREQ    <= 1'b0;
            xferFUN    <= '0;
            rpVV       <= 1'b0;
        end else if (drvCLR) begin
            state      <= ST_IDLE;
            delayCnt   <= '0;
            xferErrLat <= 1'b0;
            rpATA      <= 1'b0;
            rpILF      <= 1'b0;
            rpRMR      <= 1'b0;
            xferREQ    <= 1'b0;
        end else begin
            xferREQ <= 1'b0;
            // Clear first so any attention source below in the same cycle wins.
            if (ataCLR)
                rpATA <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (goSTB) begin
                        xferFUN <= goFUN;
                        case (goFUN)
                            FUN_NOP, FUN_RELEAS: ;
                            FUN_DRVCLR: begin
                                rpATA      <= 1'b0;
                                rpILF      <= 1'b0;
                                rpRMR      <= 1'b0;
                                xferErrLat <= 1'b0;
                            end
                            FUN_PRESET, FUN_PACK:
                                rpVV <= 1'b1;
                            FUN_SEEK, FUN_OFFSET, FUN_RTC, FUN_SEARCH: begin
                                state    <= ST_POS;
                                delayCnt <= SEEK_LOAD;
                            end
                            FUN_UNLOAD, FUN_RECAL: begin
                                state    <= ST_POS;
                                delayCnt <= RECAL_LOAD;
                                if (goFUN == FUN_UNLOAD)
                                    rpVV <= 1'b0;
                            end
                            FUN_WRCHK, FUN_WRCHKH, FUN_WRITE, FUN_WRHD,
                            FUN_READ, FUN_RDHD: begin
                                state   <= ST_XFER;
                                xferREQ <= 1'b1;
                            end
                            default: begin
                                rpILF <= 1'b1;
                                rpATA <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_POS: begin
                    if (delayCnt == '0) begin
                        state <= ST_IDLE;
                        rpATA <= 1'b1;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                ST_XFER: begin
                    if (xferDONE) begin
                        state <= ST_IDLE;
                        if (xferERR) begin
                            xferErrLat <= 1'b1;
                            rpATA      <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A GO while busy is refused without disturbing the op in flight.
            if (goSTB && state != ST_IDLE) begin
                rpRMR <= 1'b1;
                rpATA <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rp_drive_func_seq.sv
// tb/tb_rp_drive_func_seq.sv - directed self-checking bench for rp_drive_func_seq
module tb_rp_drive_func_seq;

    localparam int SEEK  = 10;
    localparam int RECAL = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       drvCLR, goSTB, ataCLR, xferDONE, xferERR;
    logic [4:0] goFUN;
    logic       rpDRY, rpATA, rpERR, rpILF, rpRMR, xferREQ, rpVV;
    logic [4:0] xferFUN;

    int assertCnt = 0;
    int failCnt   = 0;

    rp_drive_func_seq #(.SEEK_CYC(SEEK), .RECAL_CYC(RECAL), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .drvCLR(drvCLR), .goSTB(goSTB), .goFUN(goFUN),
        .ataCLR(ataCLR), .xferDONE(xferDONE), .xferERR(xferERR),
        .rpDRY(rpDRY), .rpATA(rpATA), .rpERR(rpERR), .rpILF(rpILF), .rpRMR(rpRMR),
        .xferREQ(xferREQ), .xferFUN(xferFUN), .rpVV(rpVV)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe GO for one edge; returns at cycle N+1, 1ns after the edge.
    task automatic go(input logic [4:0] fun);
        goSTB = 1'b1; goFUN = fun;
        tick();
        goSTB = 1'b0;
    endtask

    task automatic pulseDrvClr();
        drvCLR = 1'b1;
        tick();
        drvCLR = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; drvCLR = 0; goSTB = 0; goFUN = 0; ataCLR = 0; xferDONE = 0; xferERR = 0;
        #12;
        assertCnt++;
        if ({rpDRY, rpATA, rpERR, rpILF, rpRMR, xferREQ, rpVV} !== 7'b1000000) begin
            failCnt++;
            $display("FAIL reset_flags got %b want 1000000", {rpDRY, rpATA, rpERR, rpILF, rpRMR, xferREQ, rpVV});
        end
        assertCnt++;
        if (xferFUN !== 5'd0) begin failCnt++; $display("FAIL reset_fun got %0d want 0", xferFUN); end
        @(negedge clk); rst = 1'b1;
        tick();
    endtask

    task automatic test_seek();
        int lowBad = 0;
        go(5'd2);
        for (int i = 0; i < SEEK; i++) begin
            if (rpDRY !== 1'b0 || rpATA !== 1'b0) lowBad++;
            tick();
        end
        assertCnt++;
        if (lowBad != 0) begin failCnt++; $display("FAIL seek_busy bad_cycles %0d want 0", lowBad); end
        assertCnt++;
        if (rpDRY !== 1'b1 || rpATA !== 1'b1) begin
            failCnt++; $display("FAIL seek_done dry=%b ata=%b want 1 1", rpDRY, rpATA);
        end
        ataCLR = 1'b1; tick(); ataCLR = 1'b0;
        assertCnt++;
        if (rpATA !== 1'b0) begin failCnt++; $display("FAIL ata_clear got %b want 0", rpATA); end
    endtask

    task automatic test_xfer();
        go(5'd28);
        assertCnt++;
        if (xferREQ !== 1'b1 || xferFUN !== 5'd28 || rpDRY !== 1'b0) begin
            failCnt++; $display("FAIL xfer_start req=%b fun=%0d dry=%b want 1 28 0", xferREQ, xferFUN, rpDRY);
        end
        tick();
        assertCnt++;
        if (xferREQ !== 1'b0 || rpDRY !== 1'b0) begin
            failCnt++; $display("FAIL xfer_wait req=%b dry=%b want 0 0", xferREQ, rpDRY);
        end
        xferDONE = 1'b1; tick(); xferDONE = 1'b0;
        assertCnt++;
        if (rpDRY !== 1'b1 || rpATA !== 1'b0 || rpERR !== 1'b0) begin
            failCnt++; $display("FAIL xfer_done dry=%b ata=%b err=%b want 1 0 0", rpDRY, rpATA, rpERR);
        end
    endtask

    task automatic test_xfer_err();
        go(5'd28);
        tick();
        xferDONE = 1'b1; xferERR = 1'b1; tick(); xferDONE = 1'b0; xferERR = 1'b0;
        assertCnt++;
        if (rpERR !== 1'b1 || rpATA !== 1'b1 || rpDRY !== 1'b1) begin
            failCnt++; $display("FAIL xfer_err err=%b ata=%b dry=%b want 1 1 1", rpERR, rpATA, rpDRY);
        end
        go(5'd4);
        assertCnt++;
        if (rpERR !== 1'b0 || rpATA !== 1'b0) begin
            failCnt++; $display("FAIL drvclr_fun err=%b ata=%b want 0 0", rpERR, rpATA);
        end
    endtask

    task automatic test_illegal();
        go(5'd13);
        assertCnt++;
        if (rpILF !== 1'b1 || rpATA !== 1'b1 || rpDRY !== 1'b1 || rpERR !== 1'b1) begin
            failCnt++; $display("FAIL illegal ilf=%b ata=%b dry=%b err=%b want 1 1 1 1", rpILF, rpATA, rpDRY, rpERR);
        end
        pulseDrvClr();
        assertCnt++;
        if (rpILF !== 1'b0 || rpATA !== 1'b0) begin
            failCnt++; $display("FAIL illegal_clr ilf=%b ata=%b want 0 0", rpILF, rpATA);
        end
    endtask

    task automatic test_rmr();
        go(5'd2);                 // cycle N+1
        tick(); tick();           // N+3
        go(5'd2);                 // refused, now N+4
        assertCnt++;
        if (rpRMR !== 1'b1 || rpATA !== 1'b1 || rpDRY !== 1'b0 || xferFUN !== 5'd2) begin
            failCnt++; $display("FAIL rmr rmr=%b ata=%b dry=%b want 1 1 0", rpRMR, rpATA, rpDRY);
        end
        repeat (SEEK - 4) tick(); // N+10
        assertCnt++;
        if (rpDRY !== 1'b0) begin failCnt++; $display("FAIL rmr_still_busy dry=%b want 0", rpDRY); end
        tick();                   // N+11
        assertCnt++;
        if (rpDRY !== 1'b1) begin failCnt++; $display("FAIL rmr_done_time dry=%b want 1", rpDRY); end
        pulseDrvClr();
    endtask

    task automatic test_ata_race();
        go(5'd12);                // N+1
        repeat (SEEK - 1) tick(); // N+10, counter at 0
        assertCnt++;
        if (rpATA !== 1'b0 || rpDRY !== 1'b0) begin
            failCnt++; $display("FAIL race_pre ata=%b dry=%b want 0 0", rpATA, rpDRY);
        end
        ataCLR = 1'b1; tick(); ataCLR = 1'b0;
        assertCnt++;
        if (rpATA !== 1'b1 || rpDRY !== 1'b1) begin
            failCnt++; $display("FAIL race_set_wins ata=%b dry=%b want 1 1", rpATA, rpDRY);
        end
        pulseDrvClr();
    endtask

    task automatic test_drvclr_mid();
        go(5'd6);
        tick(); tick();
        pulseDrvClr();
        assertCnt++;
        if (rpDRY !== 1'b1 || rpATA !== 1'b0) begin
            failCnt++; $display("FAIL drvclr_mid dry=%b ata=%b want 1 0", rpDRY, rpATA);
        end
        repeat (SEEK + 2) tick();
        assertCnt++;
        if (rpATA !== 1'b0 || rpDRY !== 1'b1) begin
            failCnt++; $display("FAIL drvclr_no_late_ata ata=%b dry=%b want 0 1", rpATA, rpDRY);
        end
    endtask

    task automatic test_vv_unload();
        int lowBad = 0;
        go(5'd8);
        assertCnt++;
        if (rpVV !== 1'b1 || rpDRY !== 1'b1 || rpATA !== 1'b0) begin
            failCnt++; $display("FAIL preset vv=%b dry=%b ata=%b want 1 1 0", rpVV, rpDRY, rpATA);
        end
        pulseDrvClr();
        assertCnt++;
        if (rpVV !== 1'b1) begin failCnt++; $display("FAIL vv_kept got %b want 1", rpVV); end
        go(5'd1);
        assertCnt++;
        if (rpVV !== 1'b0) begin failCnt++; $display("FAIL unload_vv got %b want 0", rpVV); end
        for (int i = 0; i < RECAL; i++) begin
            if (rpDRY !== 1'b0) lowBad++;
            tick();
        end
        assertCnt++;
        if (lowBad != 0 || rpDRY !== 1'b1 || rpATA !== 1'b1) begin
            failCnt++; $display("FAIL unload_time bad=%0d dry=%b ata=%b want 0 1 1", lowBad, rpDRY, rpATA);
        end
        pulseDrvClr();
    endtask

    task automatic test_nop_idle_done();
        go(5'd0);
        assertCnt++;
        if (rpDRY !== 1'b1 || rpATA !== 1'b0 || xferREQ !== 1'b0) begin
            failCnt++; $display("FAIL nop dry=%b ata=%b req=%b want 1 0 0", rpDRY, rpATA, xferREQ);
        end
        xferDONE = 1'b1; xferERR = 1'b1; tick(); xferDONE = 1'b0; xferERR = 1'b0;
        assertCnt++;
        if (rpERR !== 1'b0 || rpATA !== 1'b0) begin
            failCnt++; $display("FAIL idle_done err=%b ata=%b want 0 0", rpERR, rpATA);
        end
    endtask

    task automatic test_back_to_back();
        drvCLR = 1'b1;
        go(5'd24);
        drvCLR = 1'b0;
        assertCnt++;
        if (xferREQ !== 1'b0 || rpDRY !== 1'b1) begin
            failCnt++; $display("FAIL drvclr_suppress req=%b dry=%b want 0 1", xferREQ, rpDRY);
        end
        go(5'd20);
        assertCnt++;
        if (xferREQ !== 1'b1 || xferFUN !== 5'd20) begin
            failCnt++; $display("FAIL wrchk_start req=%b fun=%0d want 1 20", xferREQ, xferFUN);
        end
        xferDONE = 1'b1; tick(); xferDONE = 1'b0;
        go(5'd3);
        assertCnt++;
        if (rpDRY !== 1'b0 || xferFUN !== 5'd3) begin
            failCnt++; $display("FAIL recal_start dry=%b fun=%0d want 0 3", rpDRY, xferFUN);
        end
        #3 rst = 1'b0;
        #1;
        assertCnt++;
        if (rpDRY !== 1'b1 || rpVV !== 1'b0 || xferFUN !== 5'd0) begin
            failCnt++; $display("FAIL async_rst dry=%b vv=%b fun=%0d want 1 0 0", rpDRY, rpVV, xferFUN);
        end
        @(negedge clk); rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_seek();
        test_xfer();
        test_xfer_err();
        test_illegal();
        test_rmr();
        test_ata_race();
        test_drvclr_mid();
        test_vv_unload();
        test_nop_idle_done();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
